// File: rtl/signed_addsub_acc.sv
// signed_addsub_acc: two-stage pipelined signed add / subtract / accumulate unit.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready   operand handshake (transfer on in_valid & in_ready)
//   a, b                 W-bit two's-complement operands
//   op                   00 ADD, 01 SUB, 10 ACC (acc += a), 11 LOAD (acc = a)
//   out_valid, out_ready result handshake (transfer on out_valid & out_ready)
//   sum                  exact (W+1)-bit result; sign-extended a for ACC/LOAD
//   acc                  ACC_W-bit accumulator value after this transaction
//   ovf                  ACC only: true accumulate result left the ACC_W range
//
// Stage S1 holds operands, op and the precomputed exact sum. Stage S2 is the
// output register and owns the accumulator. Capacity is two transactions.

module signed_addsub_acc #(
  parameter int unsigned W     = 4,
  parameter int unsigned ACC_W = 8,
  parameter int unsigned SAT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W:0]         sum,
  output logic [ACC_W-1:0]   acc,
  output logic               ovf
);

  localparam int unsigned SW  = W + 1;      // exact add/sub result width
  localparam int unsigned AXW = ACC_W + 1;  // accumulate width with guard bit

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // Stage S1 registers
  logic              s1_full_q, s1_full_d;
  logic [1:0]        s1_op_q,   s1_op_d;
  logic [W-1:0]      s1_a_q,    s1_a_d;
  logic [SW-1:0]     s1_sum_q,  s1_sum_d;

  // Stage S2 (output) registers
  logic              out_valid_q, out_valid_d;
  logic [SW-1:0]     sum_q,       sum_d;
  logic [ACC_W-1:0]  acc_q,       acc_d;
  logic              ovf_q,       ovf_d;

  // Handshake / datapath intermediates
  logic              s2_adv_c;
  logic              s1_move_c;
  logic              in_xfer_c;
  logic [SW-1:0]     a_x_c;
  logic [SW-1:0]     b_x_c;
  logic [SW-1:0]     pre_sum_c;
  logic [AXW-1:0]    acc_ext_c;
  logic [AXW-1:0]    a_acc_c;
  logic [AXW-1:0]    acc_sum_c;
  logic              acc_oor_c;
  logic [ACC_W-1:0]  acc_sat_c;
  logic [ACC_W-1:0]  a_load_c;

  // Pipeline flow control: S2 drains when empty or accepted downstream,
  // S1 may refill on the same edge that it moves into S2.
  always_comb begin
    s2_adv_c  = !out_valid_q || out_ready;
    s1_move_c = s1_full_q && s2_adv_c;
    in_ready  = !s1_full_q || s2_adv_c;
    in_xfer_c = in_valid && in_ready;
  end

  // Exact W+1 bit add/sub; ACC/LOAD pass sign-extended a through as sum.
  always_comb begin
    a_x_c = {a[W-1], a};
    b_x_c = {b[W-1], b};
    case (op)
      OP_ADD:  pre_sum_c = a_x_c + b_x_c;
      OP_SUB:  pre_sum_c = a_x_c - b_x_c;
      default: pre_sum_c = a_x_c;
    endcase
  end

  // S1 next state
  always_comb begin
    s1_full_d = s1_full_q;
    s1_op_d   = s1_op_q;
    s1_a_d    = s1_a_q;
    s1_sum_d  = s1_sum_q;
    if (s1_move_c) begin
      s1_full_d = 1'b0;
    end
    if (in_xfer_c) begin
      s1_full_d = 1'b1;
      s1_op_d   = op;
      s1_a_d    = a;
      s1_sum_d  = pre_sum_c;
    end
  end

  // Accumulate with one guard bit; out of range when the top two bits differ.
  always_comb begin
    acc_ext_c = {acc_q[ACC_W-1], acc_q};
    a_acc_c   = {{(AXW - W){s1_a_q[W-1]}}, s1_a_q};
    acc_sum_c = acc_ext_c + a_acc_c;
    acc_oor_c = acc_sum_c[ACC_W] ^ acc_sum_c[ACC_W-1];
    // Clamp toward the true sign: negative -> signed min, positive -> signed max.
    acc_sat_c = {acc_sum_c[ACC_W], {(ACC_W - 1){~acc_sum_c[ACC_W]}}};
    a_load_c  = {{(ACC_W - W){s1_a_q[W-1]}}, s1_a_q};
  end

  // S2 next state; all outputs hold while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    if (s2_adv_c) begin
      out_valid_d = s1_full_q;
    end
    if (s1_move_c) begin
      sum_d = s1_sum_q;
      ovf_d = 1'b0;
      case (s1_op_q)
        OP_ACC: begin
          ovf_d = acc_oor_c;
          if (acc_oor_c && (SAT != 0)) begin
            acc_d = acc_sat_c;
          end else begin
            acc_d = acc_sum_c[ACC_W-1:0];
          end
        end
        OP_LOAD: acc_d = a_load_c;
        default: acc_d = acc_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full_q   <= 1'b0;
      s1_op_q     <= 2'b00;
      s1_a_q      <= '0;
      s1_sum_q    <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_full_q   <= s1_full_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_sum_q    <= s1_sum_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_signed_addsub_acc.sv
// Bench for signed_addsub_acc: three instances (W4/ACC8 saturating, W4/ACC8
// wrapping, W8/ACC12 saturating) checked by a directed vector table, corner
// sequences and a queue-based integer reference model.
module tb_signed_addsub_acc;

  typedef struct {
    int inst; int op; int a; int b; int es; int ea; int eo;
  } vec_t;

  typedef struct {
    int inst; int cyc; int sum; int acc; int ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  logic       in_valid  [3];
  logic       out_ready [3];
  logic [7:0] a_v       [3];
  logic [7:0] b_v       [3];
  logic [1:0] op_v      [3];

  logic rdy0, rdy1, rdy2, ov0, ov1, ov2, ovf0, ovf1, ovf2;
  logic [4:0]  sum0, sum1;
  logic [8:0]  sum2;
  logic [7:0]  acc0, acc1;
  logic [11:0] acc2;

  int rdy_s [3];
  int ov_s  [3];
  int sum_s [3];
  int acc_s [3];
  int ovf_s [3];

  int   n_cmp, n_fail, cyc, lat_chk;
  int   macc    [3];
  int   acc_cnt [3];
  exp_t q [$];

  signed_addsub_acc #(.W(4), .ACC_W(8), .SAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy0),
    .a(a_v[0][3:0]), .b(b_v[0][3:0]), .op(op_v[0]), .out_valid(ov0),
    .out_ready(out_ready[0]), .sum(sum0), .acc(acc0), .ovf(ovf0));

  signed_addsub_acc #(.W(4), .ACC_W(8), .SAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy1),
    .a(a_v[1][3:0]), .b(b_v[1][3:0]), .op(op_v[1]), .out_valid(ov1),
    .out_ready(out_ready[1]), .sum(sum1), .acc(acc1), .ovf(ovf1));

  signed_addsub_acc #(.W(8), .ACC_W(12), .SAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy2),
    .a(a_v[2]), .b(b_v[2]), .op(op_v[2]), .out_valid(ov2),
    .out_ready(out_ready[2]), .sum(sum2), .acc(acc2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx(int v, int w);
    int m;
    m = v & ((1 << w) - 1);
    return (m >= (1 << (w - 1))) ? m - (1 << w) : m;
  endfunction

  function automatic int w_of(int i);
    return (i == 2) ? 8 : 4;
  endfunction

  function automatic int accw_of(int i);
    return (i == 2) ? 12 : 8;
  endfunction

  function automatic int sat_of(int i);
    return (i == 1) ? 0 : 1;
  endfunction

  always_comb begin
    rdy_s[0] = int'(rdy0); rdy_s[1] = int'(rdy1); rdy_s[2] = int'(rdy2);
    ov_s[0]  = int'(ov0);  ov_s[1]  = int'(ov1);  ov_s[2]  = int'(ov2);
    ovf_s[0] = int'(ovf0); ovf_s[1] = int'(ovf1); ovf_s[2] = int'(ovf2);
    sum_s[0] = sx(int'(sum0), 5);
    sum_s[1] = sx(int'(sum1), 5);
    sum_s[2] = sx(int'(sum2), 9);
    acc_s[0] = sx(int'(acc0), 8);
    acc_s[1] = sx(int'(acc1), 8);
    acc_s[2] = sx(int'(acc2), 12);
  end

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: integer arithmetic over the signed ranges.
  function automatic exp_t model(int i);
    exp_t e;
    int av, bv, t, mx, mn;
    av = sx(int'(a_v[i]), w_of(i));
    bv = sx(int'(b_v[i]), w_of(i));
    mx = (1 << (accw_of(i) - 1)) - 1;
    mn = -(1 << (accw_of(i) - 1));
    e.inst = i; e.cyc = cyc; e.ovf = 0; e.sum = av;
    case (int'(op_v[i]))
      0: e.sum = av + bv;
      1: e.sum = av - bv;
      2: begin
        t = macc[i] + av;
        if (t > mx || t < mn) begin
          e.ovf = 1;
          if (sat_of(i) != 0) t = (t > mx) ? mx : mn;
          else t = (t > mx) ? t - (1 << accw_of(i)) : t + (1 << accw_of(i));
        end
        macc[i] = t;
      end
      default: macc[i] = av;
    endcase
    e.acc = macc[i];
    return e;
  endfunction

  // Scoreboard: every cycle a valid output must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q.delete();
        for (int i = 0; i < 3; i++) macc[i] = 0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (ov_s[i] != 0) begin
            if (q.size() == 0 || q[0].inst != i) begin
              chk($sformatf("spurious_out%0d", i), 1, 0);
            end else begin
              e = q[0];
              chk($sformatf("sb_sum%0d", i), sum_s[i], e.sum);
              chk($sformatf("sb_acc%0d", i), acc_s[i], e.acc);
              chk($sformatf("sb_ovf%0d", i), ovf_s[i], e.ovf);
              if (out_ready[i]) begin
                if (lat_chk != 0) chk("latency", cyc - e.cyc, 2);
                q.delete(0);
              end
            end
          end
          if (in_valid[i] && rdy_s[i] != 0) begin
            q.push_back(model(i));
            acc_cnt[i]++;
          end
        end
      end
    end
  endtask

  // Present one transaction and hold it until accepted; returns at posedge+1.
  task automatic send(int i, int o, int av, int bv);
    bit done;
    done = 1'b0;
    in_valid[i] = 1'b1; op_v[i] = 2'(o); a_v[i] = 8'(av); b_v[i] = 8'(bv);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (rdy_s[i] != 0) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    in_valid[i] = 1'b0;
    if (!done) begin
      chk($sformatf("send_timeout%0d", i), 0, 1);
      @(posedge clk); #1;
    end
  endtask

  // Send, then check the result on the outputs one edge after acceptance.
  task automatic send_chk(int i, int o, int av, int bv, int es, int ea, int eo);
    send(i, o, av, bv);
    @(posedge clk); #1;
    chk($sformatf("dir_valid%0d", i), ov_s[i], 1);
    chk($sformatf("dir_sum%0d", i), sum_s[i], es);
    chk($sformatf("dir_acc%0d", i), acc_s[i], ea);
    chk($sformatf("dir_ovf%0d", i), ovf_s[i], eo);
  endtask

  task automatic drain();
    for (int c = 0; c < 500; c++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(int i, int n);
    bit fin;
    int r;
    fin = 1'b0;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          r = int'($urandom % 8);
          send(i, (r < 2) ? 0 : (r < 4) ? 1 : (r < 7) ? 2 : 3,
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        fin = 1'b1;
      end
      begin
        while (!fin) begin
          @(posedge clk); #1;
          out_ready[i] = ($urandom % 4) != 0;
        end
      end
    join
    out_ready[i] = 1'b1;
    drain();
  endtask

  vec_t tbl [10];
  int   base;

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; lat_chk = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b1;
      a_v[i] = 8'd0; b_v[i] = 8'd0; op_v[i] = 2'd0;
      macc[i] = 0; acc_cnt[i] = 0;
    end
    tbl[0] = '{0, 0, -8, -8, -16, 0, 0};
    tbl[1] = '{0, 1,  7, -8,  15, 0, 0};
    tbl[2] = '{0, 0,  7,  7,  14, 0, 0};
    tbl[3] = '{0, 1, -8,  7, -15, 0, 0};
    tbl[4] = '{0, 3, -5,  3,  -5, -5, 0};
    tbl[5] = '{0, 2,  7,  0,   7,  2, 0};
    tbl[6] = '{0, 1,  0, -8,   8,  2, 0};
    tbl[7] = '{1, 3,  7,  0,   7,  7, 0};
    tbl[8] = '{1, 2, -8,  0,  -8, -1, 0};
    tbl[9] = '{0, 0, -1,  1,   0,  2, 0};

    fork monitor(); join_none

    // Reset: an offered transaction must not be captured while rst_n is low.
    rst_n = 1'b0;
    in_valid[0] = 1'b1; op_v[0] = 2'd0; a_v[0] = 8'd3; b_v[0] = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_valid%0d", i), ov_s[i], 0);
      chk($sformatf("rst_sum%0d", i), sum_s[i], 0);
      chk($sformatf("rst_acc%0d", i), acc_s[i], 0);
      chk($sformatf("rst_ovf%0d", i), ovf_s[i], 0);
      chk($sformatf("rst_ready%0d", i), rdy_s[i], 1);
    end
    rst_n = 1'b1;
    in_valid[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_no_capture", ov_s[0], 0);

    // Directed vectors
    for (int k = 0; k < 10; k++)
      send_chk(tbl[k].inst, tbl[k].op, tbl[k].a, tbl[k].b,
               tbl[k].es, tbl[k].ea, tbl[k].eo);

    // Exhaustive ADD/SUB with acc held at 0, back-to-back, latency tracked
    send_chk(0, 3, 0, 0, 0, 0, 0);
    lat_chk = 1;
    for (int o = 0; o < 2; o++)
      for (int x = -8; x < 8; x++)
        for (int y = -8; y < 8; y++)
          send(0, o, x, y);
    drain();
    lat_chk = 0;

    // Saturation (SAT=1): positive then negative rail
    send_chk(0, 3, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 19; n++)
      send_chk(0, 2, 7, 0, 7, (n < 19) ? 7 * n : 127, (n == 19) ? 1 : 0);
    send_chk(0, 3, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 17; n++)
      send_chk(0, 2, -8, 0, -8, (n < 17) ? -8 * n : -128, (n == 17) ? 1 : 0);

    // Wrap (SAT=0)
    send_chk(1, 3, 0, 0, 0, 0, 0);
    for (int n = 1; n <= 18; n++) send_chk(1, 2, 7, 0, 7, 7 * n, 0);
    send_chk(1, 2, 7, 0, 7, -123, 1);
    send_chk(1, 2, 1, 0, 1, -122, 0);

    // Backpressure: 4 transactions, sink stalled for 5 cycles
    drain();
    out_ready[0] = 1'b0;
    base = acc_cnt[0];
    fork
      begin
        send(0, 3, 5, 0);
        send(0, 2, 3, 0);
        send(0, 2, -2, 0);
        send(0, 0, 1, 2);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepted", acc_cnt[0] - base, 2);
        chk("bp_in_ready", rdy_s[0], 0);
        chk("bp_held_sum", sum_s[0], 5);
        chk("bp_held_acc", acc_s[0], 5);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
      end
    join
    drain();
    chk("bp_final_acc", acc_s[0], 6);

    // Reset with both stages full and acc=50
    send(0, 3, 7, 0);
    for (int n = 0; n < 6; n++) send(0, 2, 7, 0);
    send(0, 2, 1, 0);
    drain();
    out_ready[0] = 1'b0;
    send(0, 0, 1, 1);
    send(0, 0, 2, 2);
    chk("mid_full_valid", ov_s[0], 1);
    chk("mid_full_acc", acc_s[0], 50);
    chk("mid_full_ready", rdy_s[0], 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov_s[0], 0);
    chk("mid_rst_sum", sum_s[0], 0);
    chk("mid_rst_acc", acc_s[0], 0);
    chk("mid_rst_ovf", ovf_s[0], 0);
    chk("mid_rst_ready", rdy_s[0], 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    send_chk(0, 2, 3, 0, 3, 3, 0);
    drain();

    // Random traffic with random source gaps and sink stalls
    rand_run(2, 300);
    rand_run(1, 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/signed_addsub_acc.md
# signed_addsub_acc

Parametrised, pipelined signed add/subtract/accumulate unit, the next generation of the team's 4-bit signed adder. It takes two W-bit two's-complement operands per transaction over a valid/ready handshake. For add and subtract it returns the exact (W+1)-bit result. For accumulate ops it also maintains a saturating or wrapping ACC_W-bit accumulator. It sits between an operand source and a result sink, and either side may stall.

## Interface
- W, default 4: operand width, two's complement; W ≥ 2.
- ACC_W, default 8: accumulator width; ACC_W ≥ W+1.
- SAT, default 1: 1 = accumulator saturates at signed max/min; 0 = accumulator wraps modulo 2^ACC_W.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand transaction present.
- in_ready  out  1  unit can accept; a transfer occurs when in_valid & in_ready at a rising edge.
- a  in  W  signed operand A.
- b  in  W  signed operand B.
- op  in  2  00 ADD (a+b), 01 SUB (a−b), 10 ACC (acc += a), 11 LOAD (acc = a).
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts; a transfer occurs when out_valid & out_ready.
- sum  out  W+1  signed result: a+b for ADD, a−b for SUB, sign-extended a for ACC/LOAD.
- acc  out  ACC_W  signed accumulator value after this transaction.
- ovf  out  1  ACC only: true result fell outside the ACC_W signed range; 0 for all other ops.

## Operation
- Two register stages: S1 (operands, op, precomputed sum) and S2 (output register: sum, acc, ovf, out_valid).
- sum is always exact. W+1 bits covers a+b over [−2^W, 2^W−2] and a−b over [−(2^W−1), 2^W−1]. No flag is needed for ADD/SUB.
- The accumulator register updates only when a transaction moves S1→S2:
  - ACC computes acc + sext(a) at ACC_W+1 bits. If SAT=1, out-of-range clamps to 2^(ACC_W−1)−1 or −2^(ACC_W−1). If SAT=0, the result is truncated.
  - ovf=1 whenever the true result is out of range, in either SAT mode.
  - LOAD sets acc = sext(a) and ovf=0.
  - ADD/SUB leave acc unchanged; acc is output with its current value.
- Back-to-back ACC/LOAD transactions see each prior update; S1 does not read acc, so there is no hazard.
- Stall logic:
  - S2 advances when !out_valid | out_ready.
  - S1 advances into S2 when S1 is full and S2 advances.
  - in_ready = !S1_full | S2 advances. This is combinational and passes no path from in_valid to in_ready.
- Outputs sum, acc, ovf and out_valid are held stable while out_valid & !out_ready.
- Transactions are never dropped, duplicated or reordered.

## Timing
- Reset (rst_n low, asynchronous):
  - S1 and S2 are emptied; out_valid=0, sum=0, acc=0, ovf=0.
  - in_ready reads 1, but no transfer is captured while rst_n is low.
- Reset mid-operation discards all in-flight transactions and the accumulator value.
- Latency: a transaction accepted at edge k appears on the outputs after edge k+1 (out_valid high during cycle k+1→k+2), with out_ready high.
- Throughput: one transaction per cycle when out_ready is held high.
- Capacity under backpressure: 2 transactions (S1 + S2). in_ready drops in the cycle both are full and out_ready=0.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle both happen; S1→S2 and new→S1 occur on the same edge.
  - in_valid is ignored when in_ready=0; the source must hold its data.

## Test plan
- Exhaustive ADD and SUB with W=4 over every (a,b) in [−8,7]², out_ready=1 → sum equals a+b and a−b exactly (e.g. −8+−8 → 5'b10000; 7−(−8) → 15), acc stays 0, ovf=0, and each result arrives 2 edges after acceptance.
- Saturation with SAT=1, ACC_W=8: LOAD 0, then 19× ACC a=7 → acc reaches 126 after 18 ops; the 19th gives acc=127 with ovf=1. Then LOAD 0 and 17× ACC a=−8 → acc=−128 with ovf=1 on the 17th.
- Wrap with SAT=0, ACC_W=8: accumulate to 126, then ACC a=7 → acc=−123 with ovf=1. A following ACC a=1 → acc=−122, ovf=0.
- Backpressure: send 4 back-to-back transactions with out_ready=0 for 5 cycles → in_ready goes low after 2 are accepted and the outputs hold stable. On release, all 4 results emerge in order and the accumulator sequence is correct.
- Reset mid-stream: assert rst_n low while both stages are full and acc=50 → out_valid, sum, acc and ovf go to 0 immediately. After release the first transaction's ACC a=3 yields acc=3.
- Parameter sweep with W=8, ACC_W=12: random ADD/SUB/ACC/LOAD traffic with random in_valid/out_ready → results match a reference model with no loss or reordering.
